// File: rtl/cube_rx.sv
// cube_rx: decodes the cube raster serial line into WORD_BITS-wide words.
// Pulse-width bit decode, latch-gap frame detection, valid/ready output.
// Ports:
//   clk, reset        single clock, async active-high reset
//   sin               raw serial line (asynchronous to clk)
//   data, data_valid  last completed word / unconsumed-word flag
//   data_ready        consumer accept (handshake when valid & ready)
//   frame_done        1-cycle pulse at each frame boundary
//   word_count        words in last completed frame (saturates at 1023)
//   err               1-cycle pulse: glitch, stuck-high, partial word, drop
//   overflow          sticky: a word was dropped
module cube_rx #(
    parameter int WORD_BITS    = 24,
    parameter int GLITCH_MAX   = 8,
    parameter int T1_MIN       = 40,
    parameter int HIGH_MAX     = 120,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sin,
    input  logic                 data_ready,
    output logic [WORD_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_done,
    output logic [9:0]           word_count,
    output logic                 err,
    output logic                 overflow
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int BW = $clog2(WORD_BITS + 1);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [LW-1:0] LOW_SAT    = {LW{1'b1}};
    localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_BITS - 1);

    // s1/s2 synchronize; s3 is the previous synchronized value for edges
    logic s1_q, s2_q, s3_q;
    logic rise, fall;

    logic [1:0]           state_q, state_d;
    logic [7:0]           high_cnt_q, high_cnt_d;
    logic [LW-1:0]        low_cnt_q, low_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [9:0]           frame_cnt_q, frame_cnt_d;
    logic                 done_q, done_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fd_q, fd_d;
    logic [9:0]           wc_q, wc_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic                 err_fsm, err_ovf;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_comb begin
        state_d     = state_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        fd_d        = 1'b0;
        wc_d        = wc_q;
        err_fsm     = 1'b0;

        unique case (state_q)
            ST_SYNC: begin
                bit_cnt_d = '0;
                if (s2_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LATCH_LAST) begin
                    low_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d     = ST_HIGH;
                    high_cnt_d  = 8'd1;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d   = ST_LOW;
                    low_cnt_d = LW'(1);
                    if (high_cnt_q <= 8'(GLITCH_MAX)) begin
                        err_fsm = 1'b1;
                    end else begin
                        shreg_d = {shreg_q[WORD_BITS-2:0],
                                   high_cnt_q >= 8'(T1_MIN)};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                            if (frame_cnt_q != 10'h3FF)
                                frame_cnt_d = frame_cnt_q + 10'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else if (high_cnt_q >= 8'(HIGH_MAX)) begin
                    // this cycle is pulse cycle HIGH_MAX+1: stuck line
                    err_fsm   = 1'b1;
                    state_d   = ST_SYNC;
                    bit_cnt_d = '0;
                    low_cnt_d = '0;
                end else if (high_cnt_q != 8'hFF) begin
                    high_cnt_d = high_cnt_q + 8'd1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = 8'd1;
                end else if (low_cnt_q == LATCH_LAST) begin
                    fd_d      = 1'b1;
                    wc_d      = frame_cnt_q;
                    err_fsm   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    low_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (low_cnt_q != LOW_SAT) begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Output word buffer: a completed word is offered one cycle after
    // completion; it is dropped if the previous one is still held.
    always_comb begin
        data_d  = data_q;
        dv_d    = dv_q;
        ovf_d   = ovf_q;
        err_ovf = 1'b0;
        if (done_q) begin
            if (dv_q && !data_ready) begin
                err_ovf = 1'b1;
                ovf_d   = 1'b1;
            end else begin
                data_d = shreg_q;
                dv_d   = 1'b1;
            end
        end else if (dv_q && data_ready) begin
            dv_d = 1'b0;
        end
        err_d = err_fsm | err_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            state_q     <= ST_SYNC;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            fd_q        <= 1'b0;
            wc_q        <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_q        <= sin;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            fd_q        <= fd_d;
            wc_q        <= wc_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_done = fd_q;
    assign word_count = wc_q;
    assign err        = err_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cube_rx.sv
// tb_cube_rx: directed stimulus for cube_rx with immediate-assertion checks.
// Drives sin on falling clock edges; monitors pulses on falling edges.
module tb_cube_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sin = 1'b0;
    logic        data_ready = 1'b1;
    logic [23:0] data;
    logic        data_valid;
    logic        frame_done;
    logic [9:0]  word_count;
    logic        err;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    int n_err = 0;
    int n_fd = 0;
    int n_dv = 0;
    int n_same = 0;
    logic dv_prev = 1'b0;

    int b_err, b_fd, b_dv, b_same;

    cube_rx dut (
        .clk(clk),
        .reset(reset),
        .sin(sin),
        .data_ready(data_ready),
        .data(data),
        .data_valid(data_valid),
        .frame_done(frame_done),
        .word_count(word_count),
        .err(err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err) n_err <= n_err + 1;
        if (frame_done) n_fd <= n_fd + 1;
        if (data_valid && !dv_prev) n_dv <= n_dv + 1;
        if (err && frame_done) n_same <= n_same + 1;
        dv_prev <= data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk);
        b_err  = n_err;
        b_fd   = n_fd;
        b_dv   = n_dv;
        b_same = n_same;
    endtask

    task automatic idle_low(input int n);
        sin = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sin = 1'b1;
        repeat (b ? 60 : 20) @(negedge clk);
        sin = 1'b0;
        repeat (b ? 40 : 80) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits,
                             input int glitch_after);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[23-i]);
            if (i == glitch_after) begin
                sin = 1'b1;
                repeat (5) @(negedge clk);
                sin = 1'b0;
                repeat (30) @(negedge clk);
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_wc", 32'(word_count), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        idle_low(2600);

        // single word, with last-bit latency check
        snap();
        send_bits(24'hA5C30F, 23, -1);
        sin = 1'b1;
        repeat (60) @(negedge clk);
        sin = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_dv_early", 32'(data_valid), 32'h0);
        @(negedge clk);
        check("lat_dv_rise", 32'(data_valid), 32'h1);
        idle_low(2600);
        check("w1_data", 32'(data), 32'hA5C30F);
        check("w1_dv_pulses", 32'(n_dv - b_dv), 32'd1);
        check("w1_dv_now", 32'(data_valid), 32'h0);
        check("w1_fd", 32'(n_fd - b_fd), 32'd1);
        check("w1_wc", 32'(word_count), 32'd1);
        check("w1_err", 32'(n_err - b_err), 32'd0);

        // three words, consumer stalled
        data_ready = 1'b0;
        snap();
        send_bits(24'h123456, 24, -1);
        send_bits(24'h654321, 24, -1);
        send_bits(24'hABCDEF, 24, -1);
        idle_low(2600);
        check("ovf_data", 32'(data), 32'h123456);
        check("ovf_dv", 32'(data_valid), 32'h1);
        check("ovf_err", 32'(n_err - b_err), 32'd2);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_wc", 32'(word_count), 32'd3);
        check("ovf_fd", 32'(n_fd - b_fd), 32'd1);
        data_ready = 1'b1;
        @(negedge clk);
        check("ovf_drain", 32'(data_valid), 32'h0);

        // glitch between bits
        snap();
        send_bits(24'h3C5A96, 24, 5);
        idle_low(2600);
        check("gl_err", 32'(n_err - b_err), 32'd1);
        check("gl_data", 32'(data), 32'h3C5A96);
        check("gl_wc", 32'(word_count), 32'd1);
        check("gl_dv", 32'(n_dv - b_dv), 32'd1);
        check("gl_ovf_sticky", 32'(overflow), 32'h1);

        // stuck-high mid word, then resync
        snap();
        send_bits(24'hFFF000, 10, -1);
        sin = 1'b1;
        repeat (200) @(negedge clk);
        idle_low(2600);
        check("stk_err", 32'(n_err - b_err), 32'd1);
        check("stk_fd", 32'(n_fd - b_fd), 32'd0);
        check("stk_dv", 32'(n_dv - b_dv), 32'd0);
        check("stk_wc", 32'(word_count), 32'd1);
        snap();
        send_bits(24'h0F0F0F, 24, -1);
        idle_low(2600);
        check("stk_next_data", 32'(data), 32'h0F0F0F);
        check("stk_next_wc", 32'(word_count), 32'd1);
        check("stk_next_fd", 32'(n_fd - b_fd), 32'd1);
        check("stk_next_err", 32'(n_err - b_err), 32'd0);

        // partial word at frame boundary
        snap();
        send_bits(24'hABC000, 12, -1);
        idle_low(2600);
        check("part_fd", 32'(n_fd - b_fd), 32'd1);
        check("part_err", 32'(n_err - b_err), 32'd1);
        check("part_same", 32'(n_same - b_same), 32'd1);
        check("part_dv", 32'(n_dv - b_dv), 32'd0);
        check("part_dv_now", 32'(data_valid), 32'h0);
        check("part_wc", 32'(word_count), 32'd0);

        // reset mid word
        send_bits(24'hC00000, 10, -1);
        sin = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        sin = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("mr_data", 32'(data), 32'h0);
        check("mr_dv", 32'(data_valid), 32'h0);
        check("mr_fd", 32'(frame_done), 32'h0);
        check("mr_wc", 32'(word_count), 32'h0);
        check("mr_err", 32'(err), 32'h0);
        check("mr_ovf", 32'(overflow), 32'h0);
        snap();
        send_bits(24'hFFFFFF, 24, -1);
        idle_low(100);
        check("mr_ignored_dv", 32'(n_dv - b_dv), 32'd0);
        check("mr_ignored_data", 32'(data), 32'h0);
        idle_low(2500);
        snap();
        send_bits(24'h5A5A5A, 24, -1);
        idle_low(2600);
        check("mr_next_data", 32'(data), 32'h5A5A5A);
        check("mr_next_wc", 32'(word_count), 32'd1);
        check("mr_next_err", 32'(n_err - b_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cube_rx.md
CUBE_RX -- requirements
Module: cube_rx

Interface
REQ-001 Parameter WORD_BITS, 24, bits per pixel word, MSB first.
REQ-002 Parameter GLITCH_MAX, 8, high pulses of GLITCH_MAX clk cycles or fewer are glitches.
REQ-003 Parameter T1_MIN, 40, high pulses of T1_MIN cycles or more decode as 1; shorter valid pulses decode as 0.
REQ-004 Parameter HIGH_MAX, 120, high pulses longer than HIGH_MAX cycles are stuck-line errors.
REQ-005 Parameter LATCH_CYCLES, 2500, low time of LATCH_CYCLES cycles or more marks a frame boundary.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 reset  input  1  asynchronous, active-high; clears all state.
REQ-008 sin  input  1  serial line in cube raster format, asynchronous to clk.
REQ-009 data  output  WORD_BITS  last completed word.
REQ-010 data_valid  output  1  data holds an unconsumed word.
REQ-011 data_ready  input  1  consumer accepts data when data_valid and data_ready are both high on a clk edge.
REQ-012 frame_done  output  1  one-cycle pulse at each detected frame boundary.
REQ-013 word_count  output  10  number of words in the last completed frame; saturates at 1023.
REQ-014 err  output  1  one-cycle pulse on glitch, stuck-high, partial word or overflow.
REQ-015 overflow  output  1  sticky; set when a word is dropped; cleared only by reset.

Function
REQ-016 sin SHALL pass through a 2-flop synchronizer; all timing below is measured on the synchronized signal s.
REQ-017 FSM states: SYNC, IDLE, HIGH, LOW.
REQ-018 SYNC: counts consecutive low cycles of s and moves to IDLE when the count reaches LATCH_CYCLES; any high cycle restarts the count at 0; no frame_done.
REQ-019 IDLE: a rising edge of s moves to HIGH with high_cnt=1, bit_cnt=0, frame word counter=0.
REQ-020 HIGH: high_cnt increments each cycle, saturating at 255; if high_cnt exceeds HIGH_MAX, pulse err and go to SYNC, discarding partial bits.
REQ-021 On a falling edge in HIGH with high_cnt <= GLITCH_MAX: pulse err, shift no bit, go to LOW.
REQ-022 On any other falling edge in HIGH: shift bit (high_cnt >= T1_MIN) into the LSB of the shift register, increment bit_cnt, go to LOW with low_cnt=1.
REQ-023 When bit_cnt reaches WORD_BITS: the word completes, bit_cnt resets to 0, and the frame word counter increments (saturating at 1023).
REQ-024 Word push: if data_valid=0, or data_ready=1 in the same cycle, data loads the word and data_valid=1 on the next cycle.
REQ-025 If data_valid=1 and data_ready=0 when a word completes, the new word is dropped; err pulses, overflow is set, and data is unchanged.
REQ-026 data_valid SHALL clear on a handshake with no simultaneous push; data SHALL be stable while data_valid=1 and data_ready=0.
REQ-027 LOW: low_cnt increments each cycle, saturating; a rising edge moves to HIGH with high_cnt=1.
REQ-028 In LOW, when low_cnt reaches LATCH_CYCLES: pulse frame_done, latch the frame word counter into word_count in the same cycle, and go to IDLE.
REQ-029 If bit_cnt != 0 at a frame boundary, err pulses in the same cycle and the partial bits are discarded.
REQ-030 Latency: a word completes 3 clk cycles after the sin falling edge of its last bit (2 synchronizer cycles plus edge detect); data_valid rises 1 cycle later.
REQ-031 err and frame_done SHALL each be high for exactly one cycle per event; simultaneous error sources produce a single err pulse.

Reset
REQ-032 Reset SHALL give state=SYNC; all counters=0; data=0; data_valid=0; frame_done=0; word_count=0; err=0; overflow=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately; after release the block requires a full LATCH_CYCLES low period in SYNC before it decodes any bits.
REQ-034 Synchronizer flops SHALL reset to 0.

Verification
REQ-035 Reset, then sin low for 2500 cycles, then one word 0xA5C30F (1 = 60 high/40 low, 0 = 20 high/80 low), data_ready=1, then low for 2500 cycles -> data=0xA5C30F and data_valid pulses once; frame_done pulses once; word_count=1; err never pulses.
REQ-036 Three words sent with data_ready=0 -> first word held in data; err pulses twice; overflow=1; word_count=3.
REQ-037 A 5-cycle high pulse inserted between bits -> err pulses once; the decoded word is unaffected.
REQ-038 sin held high for 200 cycles mid-word -> err pulses once and state returns to SYNC; next valid frame decodes correctly after 2500 low cycles.
REQ-039 12 bits followed by low for 2500 cycles -> frame_done and err pulse in the same cycle; data_valid stays 0; word_count=0.
REQ-040 Reset asserted for 1 cycle mid-word -> all outputs return to reset values; bits sent before 2500 low cycles are ignored.
